// File: rtl/photon_cnt_pkg.sv
// Shared types and constants for the photon gate counter and its pulse qualifier.
package photon_cnt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_e;

    localparam int MIN_HIGH_MAX = 15;

    function automatic int hi_run_w(input int min_high);
        return $clog2(min_high + 1);
    endfunction

endpackage

// File: rtl/photon_gate_counter_pulse_qualifier.sv
// Glitch filter: emits one qual strobe per high pulse of sig_in lasting at least MIN_HIGH cycles.
module pulse_qualifier
    import photon_cnt_pkg::*;
#(
    parameter int MIN_HIGH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic qual
);

    // Out-of-range settings are pinned to the nearest legal width rather than mis-sizing hi_run.
    localparam int MH = (MIN_HIGH < 1) ? 1 :
                        ((MIN_HIGH > MIN_HIGH_MAX) ? MIN_HIGH_MAX : MIN_HIGH);
    localparam int HW = hi_run_w(MH);
    localparam logic [HW-1:0] HI_SAT  = HW'(MH);
    localparam logic [HW-1:0] HI_QUAL = HW'(MH - 1);

    logic [HW-1:0] hi_run_q;
    logic [HW-1:0] hi_run_d;

    always_comb begin
        hi_run_d = '0;
        if (sig_in) begin
            hi_run_d = (hi_run_q == HI_SAT) ? hi_run_q : hi_run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_run_q <= '0;
        end else begin
            hi_run_q <= hi_run_d;
        end
    end

    assign qual = sig_in && (hi_run_q == HI_QUAL);

endmodule

// File: rtl/photon_gate_counter.sv
// Counts qualified photon pulses over back-to-back gate windows and hands each
// gate's count to the readout side through a valid/ready slot with overrun flagging.
//
// state | meaning
// IDLE  | not counting; waits for en to start the first gate
// GATE  | counting; each gate is max(cfg_gate_len,1) cycles, gates chain with no gap
module photon_gate_counter
    import photon_cnt_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int GATE_W   = 32,
    parameter int MIN_HIGH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic              en,
    input  logic [GATE_W-1:0] cfg_gate_len,
    output logic [CNT_W-1:0]  cnt_data,
    output logic              cnt_sat,
    output logic              cnt_valid,
    input  logic              cnt_ready,
    output logic              gate_active,
    output logic              overrun,
    input  logic              clr_overrun
);

    state_e             state_q, state_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [GATE_W-1:0]  gate_reload;
    logic [CNT_W-1:0]   acc_q, acc_d, acc_nxt;
    logic               sat_q, sat_d, sat_nxt;
    logic [CNT_W-1:0]   cnt_data_q, cnt_data_d;
    logic               cnt_sat_q, cnt_sat_d;
    logic               cnt_valid_q, cnt_valid_d;
    logic               overrun_q, overrun_d;
    logic               qual;
    logic               offer;
    logic               slot_free;
    logic               drop;

    pulse_qualifier #(
        .MIN_HIGH (MIN_HIGH)
    ) u_qual (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .qual   (qual)
    );

    // A zero length is treated as a one-cycle gate.
    assign gate_reload = (cfg_gate_len == '0) ? '0 : cfg_gate_len - 1'b1;

    always_comb begin
        acc_nxt = acc_q;
        sat_nxt = sat_q;
        if (qual) begin
            if (acc_q == '1) begin
                sat_nxt = 1'b1;
            end else begin
                acc_nxt = acc_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        offer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d    = GATE;
                    gate_cnt_d = gate_reload;
                    acc_d      = '0;
                    sat_d      = 1'b0;
                end
            end
            GATE: begin
                if (!en) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end else if (gate_cnt_q == '0) begin
                    // Closing cycle: acc_nxt already includes this cycle's qual.
                    offer      = 1'b1;
                    gate_cnt_d = gate_reload;
                    acc_d      = '0;
                    sat_d      = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                    acc_d      = acc_nxt;
                    sat_d      = sat_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slot_free   = !cnt_valid_q || cnt_ready;
        drop        = offer && !slot_free;
        cnt_data_d  = cnt_data_q;
        cnt_sat_d   = cnt_sat_q;
        cnt_valid_d = cnt_valid_q;
        overrun_d   = overrun_q;
        if (offer) begin
            if (slot_free) begin
                cnt_data_d  = acc_nxt;
                cnt_sat_d   = sat_nxt;
                cnt_valid_d = 1'b1;
            end
        end else if (cnt_ready) begin
            cnt_valid_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_data_q  <= '0;
            cnt_sat_q   <= 1'b0;
            cnt_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_data_q  <= cnt_data_d;
            cnt_sat_q   <= cnt_sat_d;
            cnt_valid_q <= cnt_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cnt_data    = cnt_data_q;
    assign cnt_sat     = cnt_sat_q;
    assign cnt_valid   = cnt_valid_q;
    assign overrun     = overrun_q;
    assign gate_active = (state_q == GATE);

endmodule

// File: tb/tb_photon_gate_counter.sv
// Directed bench for photon_gate_counter with a result scoreboard; a 6-bit instance covers saturation.
module tb_photon_gate_counter;

    localparam int CW = 8;
    localparam int GW = 8;
    localparam int MH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig_in = 1'b0;
    logic          en = 1'b0;
    logic          cnt_ready = 1'b1;
    logic          clr_overrun = 1'b0;
    logic [GW-1:0] cfg_gate_len = '0;

    logic [CW-1:0] cnt_data;
    logic          cnt_sat, cnt_valid, gate_active, overrun;
    logic [5:0]    cnt_data6;
    logic          cnt_sat6, cnt_valid6, gate_active6, overrun6;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    typedef struct {
        int data;
        int sat;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int pat0[6] = '{1, 1, 0, 1, 1, 0};
    int exp0[6] = '{0, 1, 0, 0, 1, 0};

    photon_gate_counter #(.CNT_W(CW), .GATE_W(GW), .MIN_HIGH(MH)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .cfg_gate_len(cfg_gate_len),
        .cnt_data(cnt_data), .cnt_sat(cnt_sat), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .gate_active(gate_active), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    photon_gate_counter #(.CNT_W(6), .GATE_W(GW), .MIN_HIGH(MH)) dut6 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .cfg_gate_len(cfg_gate_len),
        .cnt_data(cnt_data6), .cnt_sat(cnt_sat6), .cnt_valid(cnt_valid6), .cnt_ready(cnt_ready),
        .gate_active(gate_active6), .overrun(overrun6), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Called just before the active edge: valid && ready here means a handshake at that edge.
    task automatic mon();
        exp_t e;
        if (cnt_valid === 1'b1 && cnt_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", int'(cnt_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("cnt_data", int'(cnt_data), e.data);
                chk("cnt_sat", int'(cnt_sat), e.sat);
                if (e.cyc >= 0) chk("result_cycle", cyc_n, e.cyc);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic open_gate(input int len);
        cfg_gate_len = GW'(len);
        en = 1'b1;
        cyc();
    endtask

    // Drives one gate of len cycles with np pulses (hi high, lo low) starting at offset off.
    task automatic gate(input int len, input int hi, input int lo, input int np,
                        input int off, input int next_cfg, input bit keep);
        int n;
        int st;
        int w;
        int per;
        exp_t e;
        n = 0;
        per = hi + lo;
        for (int p = 0; p < np; p++) begin
            st = off + p * per;
            w = (len - st < hi) ? (len - st) : hi;
            if (w >= MH) n++;
        end
        if (keep) begin
            e.data = (n > 255) ? 255 : n;
            e.sat  = (n > 255) ? 1 : 0;
            e.cyc  = cnt_ready ? (cyc_n + len) : -1;
            sb.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            sig_in = (i >= off && i < off + np * per && ((i - off) % per) < hi);
            if (i == len - 1) cfg_gate_len = GW'(next_cfg);
            cyc();
        end
        sig_in = 1'b0;
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt_valid", int'(cnt_valid), 0);
        chk("rst_cnt_data", int'(cnt_data), 0);
        chk("rst_gate_active", int'(gate_active), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        cyc();
        chk("idle_gate_active", int'(gate_active), 0);

        // normal count, glitch reject, last-cycle qual, zero-length gates
        open_gate(10);
        chk("gate_active_cycle1", int'(gate_active), 1);
        gate(10, 3, 1, 3, 0, 20, 1'b1);
        gate(20, 1, 1, 5, 2, 20, 1'b1);
        gate(20, 2, 1, 1, 3, 5, 1'b1);
        gate(5, 2, 1, 1, 3, 5, 1'b1);
        gate(5, 1, 1, 0, 0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            sig_in = pat0[i][0];
            e.data = exp0[i];
            e.sat  = 0;
            e.cyc  = cyc_n + 1;
            sb.push_back(e);
            cfg_gate_len = (i == 5) ? GW'(255) : GW'(0);
            cyc();
        end
        sig_in = 1'b0;

        // saturation: 85 qualifying pulses in a 255-cycle gate
        gate(255, 2, 1, 85, 0, 255, 1'b1);
        chk("sat6_valid", int'(cnt_valid6), 1);
        chk("sat6_data", int'(cnt_data6), 63);
        chk("sat6_sat", int'(cnt_sat6), 1);
        en = 1'b0;
        cyc();
        chk("stop_gate_active", int'(gate_active), 0);
        cyc();
        chk("sb_empty_mid", sb.size(), 0);

        // back-pressure
        cnt_ready = 1'b0;
        open_gate(5);
        gate(5, 2, 1, 1, 1, 5, 1'b1);
        gate(5, 2, 1, 2, 0, 5, 1'b0);
        chk("bp_valid_held", int'(cnt_valid), 1);
        chk("bp_data_held", int'(cnt_data), 1);
        chk("bp_overrun", int'(overrun), 1);
        cnt_ready = 1'b1;
        gate(5, 1, 1, 0, 0, 5, 1'b1);
        en = 1'b0;
        cyc();
        chk("bp_overrun_sticky", int'(overrun), 1);
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        chk("bp_overrun_cleared", int'(overrun), 0);

        // abort at gate cycle 4 of 10
        open_gate(10);
        sig_in = 1'b0; cyc();
        sig_in = 1'b1; cyc();
        sig_in = 1'b1; cyc();
        en = 1'b0;
        cyc();
        chk("abort_idle", int'(gate_active), 0);
        sig_in = 1'b0;
        repeat (12) cyc();
        chk("abort_no_valid", int'(cnt_valid), 0);

        // overrun set-dominance, then asynchronous reset mid-gate
        cnt_ready = 1'b0;
        open_gate(3);
        gate(3, 2, 1, 1, 0, 3, 1'b0);
        clr_overrun = 1'b1;
        gate(3, 1, 1, 0, 0, 3, 1'b0);
        clr_overrun = 1'b0;
        chk("overrun_set_dominant", int'(overrun), 1);
        cyc();
        chk("pre_rst_valid", int'(cnt_valid), 1);
        chk("pre_rst_active", int'(gate_active), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt_valid", int'(cnt_valid), 0);
        chk("arst_cnt_data", int'(cnt_data), 0);
        chk("arst_gate_active", int'(gate_active), 0);
        chk("arst_overrun", int'(overrun), 0);
        chk("arst_cnt_sat6", int'(cnt_sat6), 0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_idle", int'(gate_active), 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
